// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed common-anode 4-digit hex display driver with per-frame input snapshot.
// Optional macro LEADING_ZERO_BLANK_EN: suppress leading zero digits 3..1 (digit 0 always shown).
module seven_seg_scanner #(
    parameter int unsigned SLOT_CYCLES = 50000,
    parameter int unsigned DEADTIME    = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned CNT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] slot_cnt_nxt;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic [15:0]      snap_digits;
    logic [15:0]      snap_digits_nxt;
    logic [3:0]       snap_en;
    logic [3:0]       snap_en_nxt;
    logic [3:0]       snap_dp;
    logic [3:0]       snap_dp_nxt;
    logic             frame_done_nxt;
    logic [3:0]       show_en;
    logic [3:0]       nibble;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;

    // Active-low segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Slot sequencing, digit advance and frame-start snapshot
    always_comb begin
        state_nxt       = state;
        slot_cnt_nxt    = slot_cnt + CNT_W'(1);
        idx_nxt         = idx;
        frame_done_nxt  = 1'b0;
        snap_digits_nxt = snap_digits;
        snap_en_nxt     = snap_en;
        snap_dp_nxt     = snap_dp;

        if (state == BLANK && idx == 2'd0 && slot_cnt == '0) begin
            snap_digits_nxt = digits_in;
            snap_en_nxt     = digit_en;
            snap_dp_nxt     = dp_in;
        end

        if (state == BLANK) begin
            if (slot_cnt == DEAD_LAST) begin
                state_nxt = DRIVE;
            end
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                state_nxt      = BLANK;
                slot_cnt_nxt   = '0;
                idx_nxt        = idx + 2'd1;
                frame_done_nxt = (idx == 2'd3);
            end
        end
    end

    // Per-digit visibility; the snapshot-next view keeps a DEADTIME of 1 coherent
    always_comb begin
        show_en = snap_en_nxt;
`ifdef LEADING_ZERO_BLANK_EN
        if (snap_digits_nxt[15:12] == 4'h0) begin
            show_en[3] = 1'b0;
        end
        if (snap_digits_nxt[11:8] == 4'h0 && !show_en[3]) begin
            show_en[2] = 1'b0;
        end
        if (snap_digits_nxt[7:4] == 4'h0 && !show_en[3] && !show_en[2]) begin
            show_en[1] = 1'b0;
        end
`endif
    end

    // Output decode for the upcoming cycle so an/seg/dp register together
    always_comb begin
        nibble  = snap_digits_nxt[{idx_nxt, 2'b00} +: 4];
        an_nxt  = 4'hF;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (state_nxt == DRIVE) begin
            seg_nxt = hex_decode(nibble);
            if (show_en[idx_nxt]) begin
                an_nxt = ~(4'b0001 << idx_nxt);
                dp_nxt = ~snap_dp_nxt[idx_nxt];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BLANK;
            slot_cnt    <= '0;
            idx         <= 2'd0;
            snap_digits <= 16'h0000;
            snap_en     <= 4'h0;
            snap_dp     <= 4'h0;
            an          <= 4'hF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            slot_cnt    <= slot_cnt_nxt;
            idx         <= idx_nxt;
            snap_digits <= snap_digits_nxt;
            snap_en     <= snap_en_nxt;
            snap_dp     <= snap_dp_nxt;
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            frame_done  <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner with SLOT_CYCLES=16, DEADTIME=4.
module tb_seven_seg_scanner;

    localparam int SLOT  = 16;
    localparam int DEAD  = 4;
    localparam int FRAME = 4 * SLOT;

    logic        clk;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_checks;
    int n_fail;

    seven_seg_scanner #(
        .SLOT_CYCLES(SLOT),
        .DEADTIME   (DEAD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digits_in (digits_in),
        .digit_en  (digit_en),
        .dp_in     (dp_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Expected {an,seg,dp,frame_done} after rising edge e (counted from reset release)
    function automatic logic [12:0] model(input int e, input logic [15:0] d,
                                          input logic [3:0] en, input logic [3:0] dpi);
        int         slot;
        int         pos;
        logic [3:0] eff;
        logic [3:0] nib;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        logic       fd;
`ifdef LEADING_ZERO_BLANK_EN
        logic       lead;
`endif
        slot  = (e / SLOT) % 4;
        pos   = e % SLOT;
        fd    = (e > 0) && (e % FRAME == 0);
        an_e  = 4'hF;
        seg_e = 7'h7F;
        dp_e  = 1'b1;
        if (pos >= DEAD) begin
            eff = en;
`ifdef LEADING_ZERO_BLANK_EN
            lead = 1'b1;
            for (int i = 3; i >= 1; i--) begin
                if (en[i]) begin
                    if (lead && 4'(d >> (i * 4)) == 4'h0) eff[i] = 1'b0;
                    else lead = 1'b0;
                end
            end
`endif
            nib   = 4'(d >> (slot * 4));
            seg_e = seg_of(nib);
            if (eff[slot]) begin
                an_e[slot] = 1'b0;
                dp_e       = ~dpi[slot];
            end
        end
        return {an_e, seg_e, dp_e, fd};
    endfunction

    task automatic do_reset(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dpi);
        reset     = 1'b0;
        digits_in = d;
        digit_en  = en;
        dp_in     = dpi;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] exp_v;
        int          pulses;
        reset     = 1'b0;
        digits_in = 16'h1234;
        digit_en  = 4'hF;
        dp_in     = 4'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        reset  = 1'b1;
        pulses = 0;
        for (int e = 1; e <= FRAME; e++) begin
            @(negedge clk);
            exp_v = model(e, 16'h1234, 4'hF, 4'h0);
            if (frame_done === 1'b1) pulses++;
            n_checks++;
            if ({an, seg, dp, frame_done} !== exp_v) begin
                n_fail++;
                $display("FAIL first_frame e=%0d got=%b exp=%b", e, {an, seg, dp, frame_done}, exp_v);
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL frame_done_count got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_snapshot();
        logic [12:0] exp_v;
        do_reset(16'h1234, 4'hF, 4'h0);
        for (int e = 1; e <= 2 * FRAME; e++) begin
            @(negedge clk);
            exp_v = model(e, (e <= FRAME) ? 16'h1234 : 16'h5678, 4'hF, 4'h0);
            n_checks++;
            if ({an, seg, dp, frame_done} !== exp_v) begin
                n_fail++;
                $display("FAIL snapshot e=%0d got=%b exp=%b", e, {an, seg, dp, frame_done}, exp_v);
            end
            if (e == 40) digits_in = 16'h5678;
        end
    endtask

    task automatic test_enable();
        logic [12:0] exp_v;
        do_reset(16'h1234, 4'b1010, 4'b0010);
        for (int e = 1; e <= 2 * FRAME; e++) begin
            @(negedge clk);
            exp_v = model(e, 16'h1234, 4'b1010, 4'b0010);
            n_checks++;
            if ({an, seg, dp, frame_done} !== exp_v) begin
                n_fail++;
                $display("FAIL enable_dp e=%0d got=%b exp=%b", e, {an, seg, dp, frame_done}, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] exp_v;
        do_reset(16'h1234, 4'hF, 4'h0);
        repeat (40) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset_drive got=%b exp=%b", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        digits_in = 16'h5678;
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= FRAME; e++) begin
            @(negedge clk);
            exp_v = model(e, 16'h5678, 4'hF, 4'h0);
            n_checks++;
            if ({an, seg, dp, frame_done} !== exp_v) begin
                n_fail++;
                $display("FAIL restart e=%0d got=%b exp=%b", e, {an, seg, dp, frame_done}, exp_v);
            end
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset_frame_done got=%b exp=%b", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_leading_zero();
        logic [12:0] exp_v;
        logic [15:0] pat;
        for (int k = 0; k < 2; k++) begin
            pat = (k == 0) ? 16'h0070 : 16'h0000;
            do_reset(pat, 4'hF, 4'h0);
            for (int e = 1; e <= FRAME; e++) begin
                @(negedge clk);
                exp_v = model(e, pat, 4'hF, 4'h0);
                n_checks++;
                if ({an, seg, dp, frame_done} !== exp_v) begin
                    n_fail++;
                    $display("FAIL zeros pat=%h e=%0d got=%b exp=%b", pat, e, {an, seg, dp, frame_done}, exp_v);
                end
            end
        end
    endtask

    task automatic test_sweep();
        logic [12:0] exp_v;
        do_reset(16'h0000, 4'hF, 4'h0);
        for (int e = 1; e <= 16 * FRAME; e++) begin
            @(negedge clk);
            exp_v = model(e, 16'(e / FRAME), 4'hF, 4'h0);
            n_checks++;
            if ({an, seg, dp, frame_done} !== exp_v) begin
                n_fail++;
                $display("FAIL sweep e=%0d got=%b exp=%b", e, {an, seg, dp, frame_done}, exp_v);
            end
            if (e % FRAME == 0) digits_in = 16'(e / FRAME);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        digits_in = 16'h0000;
        digit_en  = 4'h0;
        dp_in     = 4'h0;
        test_reset();
        test_snapshot();
        test_enable();
        test_reset_mid();
        test_leading_zero();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
